ss_scan_decode: RTL
===================

Name: ss_scan_decode

Overview:
- Reverse direction of the hex-to-7-segment path. Samples a time-multiplexed, active-low 7-segment display bus (segments plus per-digit select lines), qualifies each digit's pattern for stability, and decodes it back to a hex nibble.
- Assembles one nibble per digit into a word and pulses a frame strobe once every digit has been captured.
- Used to check display drivers in-system and to read external multiplexed displays.

Parameters:
- DIGITS, 4, number of multiplexed digits (1..8).
- STABLE_CYC, 4, consecutive identical synchronized samples required before a capture (2..255).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- seg_n  input  7  segment lines, active-low; bit0=a … bit6=g
- dig_n  input  DIGITS  digit select lines, active-low; bit k = digit k, digit 0 = least significant nibble
- value  output  4*DIGITS  last complete decoded frame
- frame_valid  output  1  one-cycle pulse when value updates
- err  output  1  set with frame_valid if any digit in that frame was undecodable
- digit_err  output  DIGITS  per-digit undecodable flags for the last frame

Behaviour:
- Input sync: seg_n and dig_n each pass through 2 flops; reset value is all-ones (inactive). The FSM sees only the synchronized sample s.
- Decode table (active-low, g..a):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
  - Any other pattern is invalid.
- "Single": exactly one dig_n bit low in s.
- FSM states: BLANK, SETTLE, HELD.
  - BLANK: if s is single -> SETTLE with cnt=1.
  - SETTLE: if s is not single -> BLANK. If s differs from the previous s (seg or dig) -> cnt=1, stay in SETTLE. If equal -> cnt++. When cnt reaches STABLE_CYC -> capture and go to HELD.
  - HELD: any change in s -> SETTLE with cnt=1 if single, else BLANK. No recapture while the pattern stays unchanged.
- Capture of digit k:
  - nib[k] <= decoded nibble, or 0 if invalid.
  - derr[k] <= invalid.
  - seen[k] <= 1.
  - Re-capturing a digit before the frame completes overwrites it (latest wins).
- Frame completion: on the edge after seen becomes all-ones:
  - value <= nib, digit_err <= derr, err <= |derr, frame_valid=1 for that one cycle.
  - seen clears on the same edge.
  - A capture arriving on that same edge sets its seen bit in the new frame.
- Latency from a stable input change to capture: 2 sync cycles + STABLE_CYC cycles. frame_valid follows the last capture by 1 cycle.
- Blanking (no select low) or multiple selects low: no capture, cnt cleared, seen retained.
- cnt is 8 bits, saturating; it never wraps.
- Reset, including mid-frame: value=0, frame_valid=0, err=0, digit_err=0, seen=0, FSM=BLANK, sync flops all-ones.

Optional Feature:
- Macro: SS_SCAN_DECODE_DP_EN.
- Defined:
  - Adds input dp_n (1, active-low decimal point, synchronized with seg_n) and output dp (DIGITS).
  - dp_n is part of the stability comparison.
  - dp[k] is captured as ~dp_n and published with value.
  - dp resets to 0.
- Undefined: no dp_n/dp ports; behaviour otherwise identical.

Decomposition:
- Package ss_pkg:
  - 7-bit seg pattern localparams SEG_0..SEG_F.
  - state enum {BLANK, SETTLE, HELD}.
  - function seg_to_nib returning {valid, nibble}.
- Sub-module ss_seg_decode: combinational 7-bit in -> 4-bit nibble + valid, wrapping seg_to_nib; instantiated once on the synchronized bus.

Test Plan (DIGITS=4, STABLE_CYC=4):
- Drive digits 0..3 with 30,24,79,40 (digit 0 first), each held 10 cycles -> one frame_valid, value=16'h0123, err=0, digit_err=0.
- Digit 2 pattern 7F (invalid), others valid -> value[11:8]=0, digit_err=4'b0100, err=1.
- Digit 1 pattern changing every 3 cycles for 30 cycles, then held -> no capture until the pattern is held 4 consecutive synchronized cycles; exactly one capture.
- dig_n=4'b1100 (two selects low) for 20 cycles -> FSM stays BLANK, no frame_valid; seen unchanged.
- rst asserted after 3 of 4 digits captured, then a full frame sent -> no stale nibbles; frame_valid only after all 4 new digits; value matches the new frame.
- With SS_SCAN_DECODE_DP_EN, dp_n low on digit 3 only -> dp=4'b1000 published with frame_valid.

Source files
------------

// File: rtl/ss_pkg.sv
// ss_pkg: shared definitions for the 7-segment scan decoder.
//   SEG_0..SEG_F : active-low segment patterns, bit order g..a (bit0 = a).
//   state_t      : digit qualification FSM states.
//   seg_to_nib   : pattern -> {valid, nibble}; unknown patterns give {0, 4'h0}.
package ss_pkg;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  typedef enum logic [1:0] {
    BLANK  = 2'd0,
    SETTLE = 2'd1,
    HELD   = 2'd2
  } state_t;

  function automatic logic [4:0] seg_to_nib(input logic [6:0] seg);
    logic [4:0] r;
    r = 5'b0;
    case (seg)
      SEG_0:   r = {1'b1, 4'h0};
      SEG_1:   r = {1'b1, 4'h1};
      SEG_2:   r = {1'b1, 4'h2};
      SEG_3:   r = {1'b1, 4'h3};
      SEG_4:   r = {1'b1, 4'h4};
      SEG_5:   r = {1'b1, 4'h5};
      SEG_6:   r = {1'b1, 4'h6};
      SEG_7:   r = {1'b1, 4'h7};
      SEG_8:   r = {1'b1, 4'h8};
      SEG_9:   r = {1'b1, 4'h9};
      SEG_A:   r = {1'b1, 4'hA};
      SEG_B:   r = {1'b1, 4'hB};
      SEG_C:   r = {1'b1, 4'hC};
      SEG_D:   r = {1'b1, 4'hD};
      SEG_E:   r = {1'b1, 4'hE};
      SEG_F:   r = {1'b1, 4'hF};
      default: r = 5'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ss_seg_decode.sv
// ss_seg_decode: combinational active-low 7-segment pattern to hex nibble.
//   seg_n [6:0] in  : segment pattern, bit0 = a .. bit6 = g, active-low
//   nib   [3:0] out : decoded nibble (0 when the pattern is not a hex glyph)
//   valid       out : pattern is one of the 16 hex glyphs
module ss_seg_decode
  import ss_pkg::*;
(
  input  logic [6:0] seg_n,
  output logic [3:0] nib,
  output logic       valid
);

  always_comb begin
    {valid, nib} = seg_to_nib(seg_n);
  end

endmodule

// File: rtl/ss_scan_decode.sv
// ss_scan_decode: samples a multiplexed active-low 7-segment bus, qualifies
// each digit for stability, decodes it and assembles a frame word.
//   clk, rst          : clock, synchronous active-high reset
//   seg_n [6:0]       : segment lines, active-low, bit0 = a .. bit6 = g
//   dig_n [DIGITS-1:0]: digit selects, active-low, bit k = digit k (k=0 is LS nibble)
//   value             : last complete frame, 4 bits per digit
//   frame_valid       : one-cycle pulse when value/digit_err/err update
//   err               : some digit of the published frame was undecodable
//   digit_err         : per-digit undecodable flags of the published frame
// Optional (macro SS_SCAN_DECODE_DP_EN):
//   dp_n              : active-low decimal point, synchronized with seg_n
//   dp [DIGITS-1:0]   : captured decimal points, published with value
// Output protocol: there is no backpressure. frame_valid is a single-cycle
// strobe; value, digit_err, err (and dp) change only on that cycle and then
// hold until the next frame, so a consumer samples them when frame_valid=1.
// The FSM state is held in `state` (type state_t) for observation.
module ss_scan_decode
  import ss_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int STABLE_CYC = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            seg_n,
  input  logic [DIGITS-1:0]     dig_n,
`ifdef SS_SCAN_DECODE_DP_EN
  input  logic                  dp_n,
  output logic [DIGITS-1:0]     dp,
`endif
  output logic [4*DIGITS-1:0]   value,
  output logic                  frame_valid,
  output logic                  err,
  output logic [DIGITS-1:0]     digit_err
);

  localparam logic [7:0] STABLE_THR = 8'(STABLE_CYC);

  // Two-flop synchronizers (q1 -> s) plus the previous synchronized sample (p).
  logic [6:0]        seg_q1, seg_s, seg_p;
  logic [DIGITS-1:0] dig_q1, dig_s, dig_p;
`ifdef SS_SCAN_DECODE_DP_EN
  logic              dp_q1, dp_s, dp_p;
  logic [DIGITS-1:0] dpc;
`endif

  state_t            state, state_n;
  logic [7:0]        cnt, cnt_n;
  logic              capture;
  logic              single;
  logic              changed;
  logic [DIGITS-1:0] seen;
  logic [4*DIGITS-1:0] nib;
  logic [DIGITS-1:0] derr;
  logic              frame_done;
  logic [3:0]        dec_nib;
  logic              dec_valid;

  ss_seg_decode u_dec (
    .seg_n (seg_s),
    .nib   (dec_nib),
    .valid (dec_valid)
  );

  always_comb begin
    single     = $onehot(~dig_s);
    frame_done = &seen;
`ifdef SS_SCAN_DECODE_DP_EN
    changed = (seg_s != seg_p) || (dig_s != dig_p) || (dp_s != dp_p);
`else
    changed = (seg_s != seg_p) || (dig_s != dig_p);
`endif
  end

  // Next-state logic. cnt counts identical consecutive samples of a single-select
  // pattern, including the one that entered SETTLE.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    capture = 1'b0;
    case (state)
      BLANK: begin
        cnt_n = 8'd0;
        if (single) begin
          state_n = SETTLE;
          cnt_n   = 8'd1;
        end
      end
      SETTLE: begin
        if (!single) begin
          state_n = BLANK;
          cnt_n   = 8'd0;
        end else if (changed) begin
          cnt_n = 8'd1;
        end else begin
          cnt_n = (cnt == 8'hFF) ? cnt : 8'(cnt + 8'd1);
          if (cnt_n >= STABLE_THR) begin
            capture = 1'b1;
            state_n = HELD;
          end
        end
      end
      HELD: begin
        if (changed) begin
          if (single) begin
            state_n = SETTLE;
            cnt_n   = 8'd1;
          end else begin
            state_n = BLANK;
            cnt_n   = 8'd0;
          end
        end
      end
      default: begin
        state_n = BLANK;
        cnt_n   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q1      <= '1;
      seg_s       <= '1;
      seg_p       <= '1;
      dig_q1      <= '1;
      dig_s       <= '1;
      dig_p       <= '1;
      state       <= BLANK;
      cnt         <= 8'd0;
      seen        <= '0;
      nib         <= '0;
      derr        <= '0;
      value       <= '0;
      frame_valid <= 1'b0;
      err         <= 1'b0;
      digit_err   <= '0;
`ifdef SS_SCAN_DECODE_DP_EN
      dp_q1       <= 1'b1;
      dp_s        <= 1'b1;
      dp_p        <= 1'b1;
      dpc         <= '0;
      dp          <= '0;
`endif
    end else begin
      seg_q1      <= seg_n;
      seg_s       <= seg_q1;
      seg_p       <= seg_s;
      dig_q1      <= dig_n;
      dig_s       <= dig_q1;
      dig_p       <= dig_s;
      state       <= state_n;
      cnt         <= cnt_n;
      frame_valid <= frame_done;
`ifdef SS_SCAN_DECODE_DP_EN
      dp_q1       <= dp_n;
      dp_s        <= dp_q1;
      dp_p        <= dp_s;
`endif
      // Publish uses the collected nibbles from before this edge's capture.
      if (frame_done) begin
        value     <= nib;
        digit_err <= derr;
        err       <= |derr;
`ifdef SS_SCAN_DECODE_DP_EN
        dp        <= dpc;
`endif
      end
      // A capture on the publishing edge starts the next frame's seen set.
      for (int k = 0; k < DIGITS; k++) begin
        if (capture && !dig_s[k]) begin
          nib[4*k +: 4] <= dec_valid ? dec_nib : 4'h0;
          derr[k]       <= !dec_valid;
          seen[k]       <= 1'b1;
`ifdef SS_SCAN_DECODE_DP_EN
          dpc[k]        <= ~dp_s;
`endif
        end else if (frame_done) begin
          seen[k] <= 1'b0;
        end
      end
    end
  end

endmodule
